// File: rtl/bram_copy_master_pkg.sv
// rtl/bram_copy_master_pkg.sv - bus widths and state encoding for the block-RAM copy engine
package bram_copy_master_pkg;

   localparam int AW = 16;
   localparam int DW = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_RD   = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/bram_copy_master.sv
// rtl/bram_copy_master.sv - block-RAM to block-RAM word copy engine behind a req/gnt arbiter
// One read cycle then one write cycle per word, ascending addresses, modulo 2^AW.
module bram_copy_master #(
   parameter int AW = bram_copy_master_pkg::AW,
   parameter int DW = bram_copy_master_pkg::DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [15:0]   length,
   output logic          busy,
   output logic          done,
   output logic          bus_req,
   input  logic          bus_gnt,
   output logic [AW-1:0] mem_addr,
   output logic          mem_cs_n,
   output logic          mem_wr_n,
   output logic          mem_rd_n,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);
   import bram_copy_master_pkg::*;

   state_e        state_q, state_d;
   logic [AW-1:0] src_q, src_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [15:0]   rem_q, rem_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (length != 16'd0) begin
                  state_d = ST_REQ;
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  rem_d   = length;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_REQ: begin
            if (bus_gnt) state_d = ST_RD;
         end
         ST_RD: state_d = ST_WR;
         ST_WR: begin
            src_d = src_q + AW'(1);
            dst_d = dst_q + AW'(1);
            rem_d = rem_q - 16'd1;
            // Grant is only re-evaluated between words, never inside one.
            if (rem_q == 16'd1)  state_d = ST_DONE;
            else if (bus_gnt)    state_d = ST_RD;
            else                 state_d = ST_REQ;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = 1'b0;
      bus_req   = 1'b0;
      mem_cs_n  = 1'b1;
      mem_wr_n  = 1'b1;
      mem_rd_n  = 1'b1;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_REQ: bus_req = 1'b1;
         ST_RD: begin
            bus_req  = 1'b1;
            mem_cs_n = 1'b0;
            mem_rd_n = 1'b0;
            mem_addr = src_q;
         end
         ST_WR: begin
            bus_req   = 1'b1;
            mem_cs_n  = 1'b0;
            mem_wr_n  = 1'b0;
            mem_addr  = dst_q;
            // RAM holds its registered read data until the next read, so it is stable for all of WR.
            mem_wdata = mem_rdata;
         end
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule
